// File: rtl/switch_debouncer.sv
// Debounces eight active-low 8-bit DIP switch banks: two-flop synchronizer per bank,
// then a per-bank stability counter that accepts a whole byte only after it has held steady.
module switch_debouncer #(
   parameter int DEBOUNCE_CYCLES = 20000,
   parameter int CNT_W           = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] dip_raw0,
   input  logic [7:0] dip_raw1,
   input  logic [7:0] dip_raw2,
   input  logic [7:0] dip_raw3,
   input  logic [7:0] dip_raw4,
   input  logic [7:0] dip_raw5,
   input  logic [7:0] dip_raw6,
   input  logic [7:0] dip_raw7,
   output logic [7:0] dip_switch0,
   output logic [7:0] dip_switch1,
   output logic [7:0] dip_switch2,
   output logic [7:0] dip_switch3,
   output logic [7:0] dip_switch4,
   output logic [7:0] dip_switch5,
   output logic [7:0] dip_switch6,
   output logic [7:0] dip_switch7,
   output logic [7:0] dip_chg,
   output logic       dip_any_chg
);

   localparam int NB = 8;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [7:0]    raw    [NB];
   logic [7:0]    stable [NB];
   logic [NB-1:0] chg_d;
   logic [NB-1:0] chg_q;
   logic          any_chg_d;
   logic          any_chg_q;

   assign raw[0] = dip_raw0;
   assign raw[1] = dip_raw1;
   assign raw[2] = dip_raw2;
   assign raw[3] = dip_raw3;
   assign raw[4] = dip_raw4;
   assign raw[5] = dip_raw5;
   assign raw[6] = dip_raw6;
   assign raw[7] = dip_raw7;

   genvar gi;
   generate
      for (gi = 0; gi < NB; gi++) begin : g_bank
         logic [7:0]       s1_q, s1_d;
         logic [7:0]       s2_q, s2_d;
         logic [7:0]       cand_q, cand_d;
         logic [7:0]       stable_q, stable_d;
         logic [CNT_W-1:0] cnt_q, cnt_d;
         logic             bank_chg_d;

         // Priority: back to stable, new candidate, count expired, keep counting.
         always_comb begin
            s1_d       = raw[gi];
            s2_d       = s1_q;
            cand_d     = cand_q;
            stable_d   = stable_q;
            cnt_d      = cnt_q;
            bank_chg_d = 1'b0;
            if (s2_q == stable_q) begin
               cnt_d  = '0;
               cand_d = s2_q;
            end else if (s2_q != cand_q) begin
               cand_d = s2_q;
               cnt_d  = '0;
            end else if (cnt_q == CNT_LAST) begin
               stable_d   = s2_q;
               cnt_d      = '0;
               bank_chg_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         always_ff @(posedge clk) begin
            if (reset) begin
               s1_q     <= 8'hFF;
               s2_q     <= 8'hFF;
               cand_q   <= 8'hFF;
               stable_q <= 8'hFF;
               cnt_q    <= '0;
            end else begin
               s1_q     <= s1_d;
               s2_q     <= s2_d;
               cand_q   <= cand_d;
               stable_q <= stable_d;
               cnt_q    <= cnt_d;
            end
         end

         assign chg_d[gi]  = bank_chg_d;
         assign stable[gi] = stable_q;
      end
   endgenerate

   // The summary flag is computed from the next-state pulses so it lines up with dip_chg.
   always_comb begin
      any_chg_d = |chg_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         chg_q     <= '0;
         any_chg_q <= 1'b0;
      end else begin
         chg_q     <= chg_d;
         any_chg_q <= any_chg_d;
      end
   end

   assign dip_switch0 = stable[0];
   assign dip_switch1 = stable[1];
   assign dip_switch2 = stable[2];
   assign dip_switch3 = stable[3];
   assign dip_switch4 = stable[4];
   assign dip_switch5 = stable[5];
   assign dip_switch6 = stable[6];
   assign dip_switch7 = stable[7];
   assign dip_chg     = chg_q;
   assign dip_any_chg = any_chg_q;

endmodule

// File: doc/switch_debouncer.md
Name: switch_debouncer

Overview:
- Conditions the eight raw 8-bit DIP switch banks from the board pins before they reach the switch bus peripheral.
- Each bank goes through a two-flop synchronizer, then a per-bank stability counter.
- Outputs are glitch-free, clock-aligned bank values, so the peripheral's change interrupt fires once per real switch movement, not once per contact bounce.
- Signal polarity is preserved: active-low in, active-low out. Inversion stays downstream.

Parameters:
- DEBOUNCE_CYCLES, 20000: number of consecutive cycles a new synchronized value must hold before it is accepted. Must be >= 1 and <= 2^CNT_W.
- CNT_W, 16: width of each bank's stability counter.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- dip_raw0..dip_raw7  input  8 each  raw asynchronous switch pins, active-low.
- dip_switch0..dip_switch7  output  8 each  debounced bank values, registered, active-low.
- dip_chg  output  8  bit g pulses high for one cycle when dip_switchg updates.
- dip_any_chg  output  1  OR of dip_chg, registered in the same cycle as dip_chg.

Behaviour:
- Clocking: all state updates on posedge clk. Reset is synchronous, active-high; clock is clk.
- Reset values:
  - sync flops s1[g], s2[g] = 8'hFF
  - dip_switchg (stable[g]) = 8'hFF (all switches off)
  - cand[g] = 8'hFF, cnt[g] = 0
  - dip_chg = 0, dip_any_chg = 0
- Synchronizer, per bank g: s1 <= dip_raw_g; s2 <= s1. No other logic samples dip_raw directly.
- Per-bank update rule, evaluated in priority order each non-reset cycle:
  1. s2 == stable: cnt <= 0; cand <= s2; chg <= 0.
  2. else s2 != cand: cand <= s2; cnt <= 0; chg <= 0. A new candidate restarts the count.
  3. else cnt == DEBOUNCE_CYCLES-1: stable <= s2; cnt <= 0; chg <= 1.
  4. else: cnt <= cnt+1; chg <= 0.
- Counter never wraps; rules 1–3 clear it before it reaches 2^CNT_W.
- Latency: raw pins change before edge E1 and then hold. s2 updates at E2, cand at E3. dip_switchg updates at edge E(3+DEBOUNCE_CYCLES). dip_chg[g] is high for exactly the following cycle.
- Glitch rejection:
  - A value that returns to stable before acceptance produces no output change and no pulse (rule 1 clears cnt).
  - A value that changes to a different unstable value restarts the count (rule 2).
- Multi-bit changes: the whole bank is accepted atomically. Every bit of the new byte must hold for the full count; a bounce on any bit restarts it.
- Bank independence: banks are fully independent. Several dip_chg bits may assert in the same cycle. dip_any_chg is registered OR, aligned with dip_chg.
- Reset mid-count: all counters and candidates clear, outputs return to FF, and no pulse is produced. After reset the first accepted value still needs the full latency.
- Power-on with switches already on: those banks report a change after 3+DEBOUNCE_CYCLES cycles. This is intended, so the downstream peripheral sees the initial state.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset, all raw = FF -> all dip_switchg = FF, dip_chg = 0 for 50 cycles.
- dip_raw0 := 8'hFE held, applied before edge E1 -> dip_switch0 = FE after E7; dip_chg = 8'h01 and dip_any_chg = 1 for exactly one cycle; other banks unchanged.
- dip_raw3 := 8'h7F for 3 cycles, then FF -> dip_switch3 stays FF; dip_chg stays 0.
- dip_raw5 goes FF -> 0F for 2 cycles, then F0 held -> no update at the first value; dip_switch5 = F0 four cycles after cand captures F0; single pulse on dip_chg[5].
- dip_raw1 = 0x00 and dip_raw7 = 0xAA changed in the same cycle -> both outputs update at the same edge; dip_chg = 8'h82 for one cycle.
- dip_raw2 = 0x55 held; reset asserted when cnt = 2, released one cycle later -> dip_switch2 = FF during reset, no pulse; after release it takes the full latency, then 0x55 with one pulse.
